sc_sng_bank_param: RTL and testbench

//  Parametrised stochastic-number-generator bank at the digital-to-analog boundary of the SC crossbar.
//  Per-row weight LFSRs drive the weight DACs (WLFSR); per-column input LFSRs feed comparators that turn

---
 rtl/sc_sng_pkg.sv | 38 +++
 rtl/sc_lfsr_galois.sv | 35 +++
 rtl/sc_sng_bank_param.sv | 187 ++++++++++++++++++
 tb/tb_sc_sng_bank_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_sng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_sng_pkg : shared types and helpers for the SC stochastic-number bank    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sc_sng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } sng_state_e;

  // Right-shift Galois feedback masks for maximal-length sequences
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      default: return 32'h1 << (width - 1);
    endcase
  endfunction

  function automatic int elem_idx(input int r, input int c, input int n_col);
    return r * n_col + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_lfsr_galois.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_lfsr_galois : loadable Galois LFSR with zero-seed lock-up guard         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sc_lfsr_galois
  import sc_sng_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'hB8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= WIDTH'(1);
    end else if (load) begin
      r_state <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (en) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/sc_sng_bank_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_sng_bank_param : weight/input LFSR bank and SC comparator array with a  |
// | burst sequencer feeding the crossbar D2A boundary.           Rev 1.0       |
// +----------------------------------------------------------------------------+
module sc_sng_bank_param
  import sc_sng_pkg::*;
#(
  parameter int N_ROW = 81,
  parameter int N_COL = 32,
  parameter int FXP   = 8,
  parameter int LEN_W = 10
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           lfsr_load,
  input  logic [$clog2(N_ROW+N_COL)-1:0] lfsr_sel,
  input  logic [FXP-1:0]                 lfsr_seed,
  input  logic                           rd_en,
  input  logic [$clog2(N_ROW+N_COL)-1:0] rd_addr,
  output logic [FXP-1:0]                 rd_data,
  output logic                           rd_valid,
  input  logic [N_ROW*N_COL*FXP-1:0]     FXPIN,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           bipolar_en,
  input  logic [LEN_W-1:0]               stream_len,
  output logic [N_ROW*N_COL-1:0]         SC_WL,
  output logic [N_ROW*FXP-1:0]           WLFSR,
  output logic                           sc_valid,
  output logic                           phase_pos,
  output logic                           busy,
  output logic                           done
);

  localparam int                c_n_lfsr   = N_ROW + N_COL;
  localparam int                c_sw       = $clog2(c_n_lfsr);
  localparam logic [c_sw:0]     c_n_lfsr_w = (c_sw + 1)'(c_n_lfsr);
  localparam logic [FXP-1:0]    c_taps     = FXP'(lfsr_taps(FXP));

  sng_state_e             r_state, w_state_nxt;
  logic [LEN_W-1:0]       r_cnt, w_cnt_nxt, r_len;
  logic                   r_bip;
  logic                   w_idle, w_run, w_last, w_start_ok, w_load_ok, w_rd_in_range;
  logic [FXP-1:0]         w_seed_fix;
  logic [FXP-1:0]         w_states [c_n_lfsr];
  logic [N_ROW*N_COL-1:0] w_sc_bits;
  logic [N_ROW*FXP-1:0]   w_wstate;

  logic [FXP-1:0]         r_rd_data;
  logic                   r_rd_valid, r_sc_valid, r_phase_pos, r_busy, r_done;
  logic [N_ROW*N_COL-1:0] r_sc_wl;
  logic [N_ROW*FXP-1:0]   r_wlfsr;

  assign w_idle        = (r_state == IDLE);
  assign w_run         = ((r_state == POS) || (r_state == NEG)) && !abort;
  assign w_last        = (r_cnt == r_len - LEN_W'(1));
  assign w_start_ok    = start && !abort && w_idle;
  assign w_load_ok     = lfsr_load && w_idle && ({1'b0, lfsr_sel} < c_n_lfsr_w);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_n_lfsr_w);
  assign w_seed_fix    = (lfsr_seed == '0) ? FXP'(1) : lfsr_seed;

  // ---------------- sequencer ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_bip   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start_ok) begin
        r_len <= stream_len;
        r_bip <= bipolar_en;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_state_nxt = (stream_len == '0) ? FIN : POS;
          w_cnt_nxt   = '0;
        end
        POS: if (w_last) begin
          w_state_nxt = r_bip ? NEG : FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
        end
        NEG: if (w_last) begin
          w_state_nxt = FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
        end
        FIN:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- LFSR bank: weights first, then inputs ----------------
  for (genvar g = 0; g < c_n_lfsr; g++) begin : g_lfsr
    sc_lfsr_galois #(.WIDTH(FXP), .TAPS(c_taps)) u_lfsr (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .load    (w_load_ok && (lfsr_sel == c_sw'(g))),
      .seed    (lfsr_seed),
      .en      (w_run),
      .state   (w_states[g])
    );
  end

  for (genvar r = 0; r < N_ROW; r++) begin : g_wout
    assign w_wstate[r*FXP +: FXP] = w_states[r];
  end

  // ---------------- comparator array ----------------
  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    for (genvar c = 0; c < N_COL; c++) begin : g_col
      localparam int c_e = elem_idx(r, c, N_COL);
      logic signed [FXP-1:0] w_x;
      logic [FXP-1:0]        w_abs, w_rnd;
      logic [FXP-2:0]        w_mag;
      logic                  w_pos, w_neg;

      assign w_x = FXPIN[c_e*FXP +: FXP];
      // Per-row rotation decorrelates rows that share one input LFSR
      for (genvar b = 0; b < FXP; b++) begin : g_rot
        assign w_rnd[b] = w_states[N_ROW+c][(b - (r % FXP) + FXP) % FXP];
      end
      assign w_abs = w_x[FXP-1] ? -w_x : w_x;
      assign w_mag = w_abs[FXP-1] ? '1 : w_abs[FXP-2:0];
      assign w_pos = !w_x[FXP-1] && (w_x != '0);
      assign w_neg = w_x[FXP-1];
      assign w_sc_bits[c_e] = ((r_state == POS) ? w_pos : w_neg) && (w_rnd[FXP-2:0] < w_mag);
    end
  end

  // ---------------- D2A output register and readback ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sc_valid  <= 1'b0;
      r_phase_pos <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sc_wl     <= '0;
      r_wlfsr     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_sc_valid <= w_run;
      r_done     <= (r_state == FIN) && !abort;
      r_busy     <= !w_idle && !abort;
      if (w_run) begin
        r_sc_wl     <= w_sc_bits;
        r_wlfsr     <= w_wstate;
        r_phase_pos <= (r_state == POS);
      end
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (w_load_ok && (lfsr_sel == rd_addr)) r_rd_data <= w_seed_fix;
        else if (w_rd_in_range)                 r_rd_data <= w_states[rd_addr];
        else                                    r_rd_data <= '0;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign SC_WL     = r_sc_wl;
  assign WLFSR     = r_wlfsr;
  assign sc_valid  = r_sc_valid;
  assign phase_pos = r_phase_pos;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_sng_bank_param.sv
`default_nettype none
// Scoreboard bench for sc_sng_bank_param (N_ROW=4, N_COL=2, FXP=8, LEN_W=6).
module tb_sc_sng_bank_param;

  localparam int NR = 4, NC = 2, FX = 8, LW = 6, NL = 6;

  logic          CLK = 1'b0, RESET_N = 1'b1;
  logic          lfsr_load = 0, rd_en = 0, start = 0, abort = 0, bipolar_en = 0;
  logic [2:0]    lfsr_sel = 0, rd_addr = 0;
  logic [7:0]    lfsr_seed = 0, rd_data;
  logic          rd_valid, sc_valid, phase_pos, busy, done;
  logic [63:0]   FXPIN = '0;
  logic [LW-1:0] stream_len = '0;
  logic [7:0]    SC_WL;
  logic [31:0]   WLFSR;
  bit            clk_en = 0;

  sc_sng_bank_param #(.N_ROW(NR), .N_COL(NC), .FXP(FX), .LEN_W(LW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .lfsr_load(lfsr_load), .lfsr_sel(lfsr_sel),
    .lfsr_seed(lfsr_seed), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .FXPIN(FXPIN), .start(start), .abort(abort),
    .bipolar_en(bipolar_en), .stream_len(stream_len), .SC_WL(SC_WL), .WLFSR(WLFSR),
    .sc_valid(sc_valid), .phase_pos(phase_pos), .busy(busy), .done(done)
  );

  always #5 if (clk_en) CLK = ~CLK;

  typedef struct { logic [7:0] wl; logic [31:0] w; bit pos; } beat_t;
  beat_t      beat_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] m_st [NL];
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] adv(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] model_wl(input bit pos);
    logic [7:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        logic signed [7:0] x;
        logic [7:0] rnd;
        int mag;
        x   = FXPIN[(r*NC+c)*8 +: 8];
        rnd = rotl(m_st[NR+c], r % 8);
        mag = (x < 0) ? -int'(x) : int'(x);
        if (mag > 127) mag = 127;
        v[r*NC+c] = (pos ? (x > 0) : (x < 0)) && (int'(rnd[6:0]) < mag);
      end
    end
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input int a);
    rd_en = 1; rd_addr = 3'(a);
    rd_q.push_back((a < NL) ? m_st[a] : 8'h00);
    step();
    rd_en = 0;
  endtask

  task automatic load(input int sel, input logic [7:0] seed);
    lfsr_load = 1; lfsr_sel = 3'(sel); lfsr_seed = seed;
    if (sel < NL) m_st[sel] = (seed == 0) ? 8'h01 : seed;
    step();
    lfsr_load = 0;
  endtask

  task automatic set_x(input int r, input int c, input logic [7:0] v);
    FXPIN[(r*NC+c)*8 +: 8] = v;
  endtask

  // Issues one burst, queues the expected beats, and checks the cycle timing
  task automatic run_burst(input int L, input bit bip, input int abort_beat,
                           input bit load_busy, input bit start_busy);
    int nb, n_valid, n_pos, n_done, t_first, done_cyc, busy_last, abort_cyc, exp_pos;
    nb = bip ? 2 * L : L;
    if (abort_beat > 0) nb = abort_beat;
    for (int k = 0; k < nb; k++) begin
      beat_t b;
      b.pos = (k < L);
      b.wl  = model_wl(b.pos);
      b.w   = {m_st[3], m_st[2], m_st[1], m_st[0]};
      beat_q.push_back(b);
      for (int j = 0; j < NL; j++) m_st[j] = adv(m_st[j]);
    end
    n_valid = 0; n_pos = 0; n_done = 0; t_first = -1; done_cyc = -1;
    busy_last = -1; abort_cyc = -1;
    stream_len = LW'(L); bipolar_en = bip; start = 1;
    for (int i = 1; i <= (bip ? 2 * L : L) + 8; i++) begin
      step();
      start = 0; lfsr_load = 0; abort = 0;
      if (sc_valid) begin
        n_valid++;
        if (t_first < 0) t_first = i;
        if (phase_pos) n_pos++;
      end
      if (done) begin n_done++; done_cyc = i; end
      if (busy) busy_last = i;
      if (load_busy && i == 3) begin lfsr_load = 1; lfsr_sel = 0; lfsr_seed = 8'h77; end
      if (start_busy && i == 2) start = 1;
      if (abort_beat > 0 && abort_cyc < 0 && n_valid == abort_beat) begin
        abort = 1; abort_cyc = i;
      end
    end
    exp_pos = (abort_beat > 0) ? nb : L;
    chk("beat_count", n_valid, nb);
    if (nb > 0) chk("first_beat_cycle", t_first, 2);
    chk("pos_beats", n_pos, exp_pos);
    if (abort_beat > 0) begin
      chk("abort_no_done", n_done, 0);
      chk("abort_busy_last", busy_last, abort_cyc);
    end else begin
      chk("done_count", n_done, 1);
      chk("done_cycle", done_cyc, 2 + (bip ? 2 * L : L));
      chk("busy_last_cycle", busy_last, done_cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or readback
  always @(posedge CLK) begin
    #2;
    if (sc_valid) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        beat_t b;
        b = beat_q.pop_front();
        chk("sc_wl", SC_WL, b.wl);
        chk("wlfsr", WLFSR, b.w);
        chk("phase_pos", phase_pos, b.pos);
      end
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int j = 0; j < NL; j++) m_st[j] = 8'h01;
    // 1. reset without clocks
    #1 RESET_N = 0;
    #1;
    chk("rst_sc_wl", SC_WL, 0);
    chk("rst_wlfsr", WLFSR, 0);
    chk("rst_flags", {rd_valid, sc_valid, phase_pos, busy, done}, 0);
    chk("rst_rd_data", rd_data, 0);
    clk_en = 1;
    step(); step();
    RESET_N = 1;
    step();
    for (int a = 0; a < NL; a++) rd(a);
    rd(7);
    // 2. seed load and readback
    load(6, 8'h33);
    load(1, 8'hA5);
    rd(1);
    load(4, 8'h00);
    rd(4);
    lfsr_load = 1; lfsr_sel = 2; lfsr_seed = 8'h5A; m_st[2] = 8'h5A;
    rd(2);
    lfsr_load = 0;
    // 3. zero activations, unipolar, load attempted while busy
    FXPIN = '0;
    run_burst(16, 0, 0, 1, 0);
    rd(0);
    // 4. bipolar with mixed activations
    set_x(0, 0, 8'h7F); set_x(0, 1, 8'h7F);
    set_x(1, 0, 8'h81); set_x(1, 1, 8'h81);
    set_x(2, 0, 8'h40); set_x(2, 1, 8'hFF);
    set_x(3, 0, 8'h80); set_x(3, 1, 8'h01);
    run_burst(10, 1, 0, 0, 0);
    // 5. abort during the 5th POS beat
    run_burst(20, 0, 5, 0, 0);
    for (int a = 0; a < NL; a++) rd(a);
    // 6. zero-length burst, then start pulse while busy
    run_burst(0, 0, 0, 0, 0);
    run_burst(3, 0, 0, 0, 1);
    repeat (4) step();
    chk("beat_q_empty", beat_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
